// File: rtl/control_splitter_if.sv
// Frame-splitter bus: groups the snapshot/control inputs and the pipe-out
// side signals of control_splitter.
//   combinedin      packed frame, word k at [k*WIDTH +: WIDTH]
//   capture/abort   one-cycle control strobes
//   ep_read         pipe-out read strobe, one word per high cycle
//   ep_datain       registered word presented to the pipe-out endpoint
//   words_left      words remaining in the current frame
//   busy/frame_done status; underflow/capture_dropped sticky flags
interface control_splitter_if #(
  parameter int unsigned NWORDS = 64,
  parameter int unsigned WIDTH  = 16
);
  logic [NWORDS*WIDTH-1:0] combinedin;
  logic                    capture;
  logic                    abort;
  logic                    ep_read;
  logic [WIDTH-1:0]        ep_datain;
  logic [6:0]              words_left;
  logic                    busy;
  logic                    frame_done;
  logic                    underflow;
  logic                    capture_dropped;

  modport master (
    output combinedin, capture, abort, ep_read,
    input  ep_datain, words_left, busy, frame_done, underflow, capture_dropped
  );

  modport slave (
    input  combinedin, capture, abort, ep_read,
    output ep_datain, words_left, busy, frame_done, underflow, capture_dropped
  );
endinterface

// File: rtl/control_splitter.sv
// Snapshots a packed NWORDS x WIDTH frame into a shadow buffer on capture and
// streams it out word 0 first to a pipe-out endpoint, one word per ep_read.
//   clk      rising-edge clock (pipe-out ti_clk domain)
//   reset_n  asynchronous active-low reset, deassertion synchronised inside
//   bus      control_splitter_if slave: frame input, strobes, data and status
module control_splitter #(
  parameter int unsigned NWORDS = 64,
  parameter int unsigned WIDTH  = 16
) (
  input logic              clk,
  input logic              reset_n,
  control_splitter_if.slave bus
);

  localparam int unsigned IdxW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [6:0]  WlInit = 7'(NWORDS);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLoaded = 2'd1;
  localparam logic [1:0] StDrain  = 2'd2;

  // Reset: asserts immediately, releases two edges after reset_n rises.
  logic rst_q1, rst_q2;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_q1 <= 1'b0;
      rst_q2 <= 1'b0;
    end else begin
      rst_q1 <= 1'b1;
      rst_q2 <= rst_q1;
    end
  end

  logic rst_int_n;
  assign rst_int_n = rst_q2;

  logic [1:0]       state_q, state_d;
  logic [IdxW-1:0]  index_q, index_d, index_nxt;
  logic [6:0]       wl_q, wl_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             uf_q, uf_d;
  logic             cd_q, cd_d;
  logic             load;

  logic [WIDTH-1:0] shadow_q [NWORDS];

  assign index_nxt = index_q + IdxW'(1);

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    wl_d    = wl_q;
    data_d  = data_q;
    done_d  = 1'b0;
    uf_d    = uf_q;
    cd_d    = cd_q;
    load    = 1'b0;
    if (bus.abort) begin
      // Flush wins over capture and ep_read; flags untouched, no done pulse.
      state_d = StIdle;
      index_d = '0;
      wl_d    = '0;
      data_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.capture) begin
            load    = 1'b1;
            state_d = StLoaded;
            index_d = '0;
            wl_d    = WlInit;
            data_d  = bus.combinedin[WIDTH-1:0];
            uf_d    = 1'b0;
            cd_d    = 1'b0;
          end else if (bus.ep_read) begin
            uf_d = 1'b1;
          end
        end
        StLoaded, StDrain: begin
          if (bus.capture) begin
            cd_d = 1'b1;
          end
          if (bus.ep_read) begin
            if (wl_q == 7'd1) begin
              // Last word consumed: return to idle without indexing past the end.
              state_d = StIdle;
              index_d = '0;
              wl_d    = '0;
              data_d  = '0;
              done_d  = 1'b1;
            end else begin
              state_d = StDrain;
              index_d = index_nxt;
              wl_d    = wl_q - 7'd1;
              data_d  = shadow_q[index_nxt];
            end
          end
        end
        default: begin
          state_d = StIdle;
          index_d = '0;
          wl_d    = '0;
          data_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= StIdle;
      index_q <= '0;
      wl_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      uf_q    <= 1'b0;
      cd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      wl_q    <= wl_d;
      data_q  <= data_d;
      done_q  <= done_d;
      uf_q    <= uf_d;
      cd_q    <= cd_d;
    end
  end

  // Shadow contents need no reset: they only reach ep_datain after a load.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < int'(NWORDS); k++) begin
        shadow_q[k] <= bus.combinedin[k*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.ep_datain       = data_q;
  assign bus.words_left      = wl_q;
  assign bus.busy            = (state_q != StIdle);
  assign bus.frame_done      = done_q;
  assign bus.underflow       = uf_q;
  assign bus.capture_dropped = cd_q;

endmodule

// File: tb/tb_control_splitter.sv
module tb_control_splitter;
  localparam int unsigned NW = 64;
  localparam int unsigned W  = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  control_splitter_if #(.NWORDS(NW), .WIDTH(W)) bus ();

  control_splitter #(.NWORDS(NW), .WIDTH(W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input logic [15:0] base);
    for (int k = 0; k < int'(NW); k++) begin
      bus.combinedin[k*W +: W] = base + 16'(k);
    end
  endtask

  task automatic cap(input logic [15:0] base);
    set_frame(base);
    bus.capture = 1'b1;
    tick();
    bus.capture = 1'b0;
    chk("cap_busy", 32'(bus.busy), 32'd1);
    chk("cap_wl", 32'(bus.words_left), 32'd64);
    chk("cap_data", 32'(bus.ep_datain), 32'(base));
    chk("cap_uf_clr", 32'(bus.underflow), 32'd0);
    chk("cap_cd_clr", 32'(bus.capture_dropped), 32'd0);
  endtask

  // Back-to-back reads of words start..start+n-1.
  task automatic read_n(input logic [15:0] base, input int unsigned start, input int unsigned n);
    bus.ep_read = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      chk("rd_data", 32'(bus.ep_datain), 32'(base + 16'(start + i)));
      chk("rd_wl", 32'(bus.words_left), 32'(64 - (start + i)));
      chk("rd_done_low", 32'(bus.frame_done), 32'd0);
      tick();
    end
    bus.ep_read = 1'b0;
  endtask

  task automatic chk_done();
    chk("done_pulse", 32'(bus.frame_done), 32'd1);
    chk("done_busy", 32'(bus.busy), 32'd0);
    chk("done_wl", 32'(bus.words_left), 32'd0);
    chk("done_data", 32'(bus.ep_datain), 32'd0);
    tick();
    chk("done_once", 32'(bus.frame_done), 32'd0);
  endtask

  initial begin
    int unsigned idx;
    logic        rd;
    bus.combinedin = '0;
    bus.capture    = 1'b0;
    bus.abort      = 1'b0;
    bus.ep_read    = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_wl", 32'(bus.words_left), 32'd0);
    chk("rst_data", 32'(bus.ep_datain), 32'd0);
    chk("rst_done", 32'(bus.frame_done), 32'd0);
    chk("rst_uf", 32'(bus.underflow), 32'd0);
    chk("rst_cd", 32'(bus.capture_dropped), 32'd0);

    // Capture on the first edge after release must not be accepted
    #2;
    reset_n = 1'b1;
    set_frame(16'h1000);
    bus.capture = 1'b1;
    tick();
    bus.capture = 1'b0;
    chk("sync_busy", 32'(bus.busy), 32'd0);
    tick();
    tick();

    // Basic frame
    cap(16'h1000);
    read_n(16'h1000, 0, 64);
    chk_done();

    // Stalls 1,0,0,1; capture with the final read is dropped
    cap(16'h1000);
    idx = 0;
    for (int c = 0; c < 400 && idx < 64; c++) begin
      chk("st_data", 32'(bus.ep_datain), 32'(16'h1000 + 16'(idx)));
      chk("st_wl", 32'(bus.words_left), 32'(64 - idx));
      rd = ((c % 4) == 0) || ((c % 4) == 3);
      bus.ep_read = rd;
      bus.capture = rd && (idx == 63);
      tick();
      bus.ep_read = 1'b0;
      bus.capture = 1'b0;
      if (rd) idx++;
    end
    chk("st_last_done", 32'(bus.frame_done), 32'd1);
    chk("st_last_cd", 32'(bus.capture_dropped), 32'd1);
    chk("st_last_busy", 32'(bus.busy), 32'd0);
    tick();

    // Snapshot isolation
    cap(16'h1000);
    bus.combinedin = '1;
    read_n(16'h1000, 0, 64);
    chk_done();

    // Dropped capture during word 10, then underflow in idle
    cap(16'h2000);
    read_n(16'h2000, 0, 10);
    set_frame(16'h3000);
    bus.capture = 1'b1;
    tick();
    bus.capture = 1'b0;
    chk("drop_cd", 32'(bus.capture_dropped), 32'd1);
    chk("drop_data", 32'(bus.ep_datain), 32'h200A);
    chk("drop_wl", 32'(bus.words_left), 32'd54);
    read_n(16'h2000, 10, 54);
    chk_done();
    bus.ep_read = 1'b1;
    tick();
    bus.ep_read = 1'b0;
    chk("uf_set", 32'(bus.underflow), 32'd1);
    chk("uf_data", 32'(bus.ep_datain), 32'd0);
    chk("uf_busy", 32'(bus.busy), 32'd0);
    chk("uf_cd_sticky", 32'(bus.capture_dropped), 32'd1);
    cap(16'h3000);

    // Abort after 20 reads
    read_n(16'h3000, 0, 20);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("ab_busy", 32'(bus.busy), 32'd0);
    chk("ab_wl", 32'(bus.words_left), 32'd0);
    chk("ab_data", 32'(bus.ep_datain), 32'd0);
    chk("ab_done", 32'(bus.frame_done), 32'd0);
    tick();
    chk("ab_done2", 32'(bus.frame_done), 32'd0);

    // Abort together with capture
    set_frame(16'h3100);
    bus.capture = 1'b1;
    bus.abort   = 1'b1;
    tick();
    bus.capture = 1'b0;
    bus.abort   = 1'b0;
    chk("abcap_busy", 32'(bus.busy), 32'd0);
    chk("abcap_wl", 32'(bus.words_left), 32'd0);
    chk("abcap_data", 32'(bus.ep_datain), 32'd0);

    // Reset mid-frame at word 33, asynchronously
    cap(16'h4000);
    read_n(16'h4000, 0, 33);
    bus.capture = 1'b1;
    tick();
    bus.capture = 1'b0;
    chk("mr_cd", 32'(bus.capture_dropped), 32'd1);
    chk("mr_data", 32'(bus.ep_datain), 32'h4021);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mr_busy", 32'(bus.busy), 32'd0);
    chk("mr_wl", 32'(bus.words_left), 32'd0);
    chk("mr_data0", 32'(bus.ep_datain), 32'd0);
    chk("mr_done", 32'(bus.frame_done), 32'd0);
    chk("mr_uf", 32'(bus.underflow), 32'd0);
    chk("mr_cd0", 32'(bus.capture_dropped), 32'd0);
    tick();
    chk("mr_done_hold", 32'(bus.frame_done), 32'd0);
    #2;
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    cap(16'h5000);
    read_n(16'h5000, 0, 64);
    chk_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/control_splitter.md
CONTROL_SPLITTER -- requirements
Module: control_splitter

Interface
REQ-001 Parameter NWORDS, default 64: number of 16-bit words per frame.
REQ-002 Parameter WIDTH, default 16: word width in bits.
REQ-003 clk  input  1  single clock, the ti_clk domain of the pipe-out endpoint; all logic rising-edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 combinedin  input  NWORDS*WIDTH  packed frame; word k occupies bits [k*WIDTH +: WIDTH].
REQ-006 capture  input  1  one-cycle strobe: snapshot combinedin into the shadow buffer.
REQ-007 abort  input  1  synchronous flush of the frame in progress.
REQ-008 ep_read  input  1  read strobe from the pipe-out endpoint; one word consumed per high cycle.
REQ-009 ep_datain  output  WIDTH  word presented to the pipe-out endpoint.
REQ-010 words_left  output  7  words remaining in the current frame.
REQ-011 busy  output  1  high in LOADED or DRAIN.
REQ-012 frame_done  output  1  one-cycle pulse after the last word is consumed.
REQ-013 underflow  output  1  sticky: ep_read was seen with no word available.
REQ-014 capture_dropped  output  1  sticky: capture was ignored because a frame was active.

Function
REQ-015 States: IDLE, LOADED, DRAIN.
REQ-016 IDLE with capture=1: copy combinedin to shadow, set index=0, set words_left=NWORDS, go to LOADED.
REQ-017 LOADED with ep_read=1: index increments, words_left decrements, go to DRAIN.
REQ-018 DRAIN with ep_read=1:
- index increments and words_left decrements.
- When words_left goes 1->0: pulse frame_done, go to IDLE.
REQ-019 ep_read=0 in LOADED or DRAIN: state, index and words_left hold; stalls of any length are legal.
REQ-020 ep_datain = shadow word[index], driven from a register.
- Updated in the same edge that advances index, so the next word is valid the cycle after a read.
- Combinational path from ep_read to ep_datain is forbidden.
REQ-021 In IDLE, ep_datain=0x0000.
REQ-022 Word order: word 0 (LSBs of combinedin) first, word NWORDS-1 last, bits unchanged.
REQ-023 Shadow buffer is written only on an accepted capture; changes on combinedin after capture never affect output.
REQ-024 capture while busy:
- Ignored; shadow, index and state are unchanged.
- capture_dropped sets.
REQ-025 capture and the final ep_read in the same cycle: capture is dropped (state is still DRAIN), frame_done pulses, capture_dropped sets.
REQ-026 ep_read in IDLE: no state change, ep_datain stays 0x0000, underflow sets.
REQ-027 abort=1 (any state):
- Next state IDLE, words_left=0, ep_datain=0x0000.
- No frame_done pulse.
- abort has priority over capture and ep_read in the same cycle.
REQ-028 Sticky flags clear only on reset or on an accepted capture.
REQ-029 words_left never wraps: it is 0 in IDLE and 1..NWORDS otherwise.
REQ-030 Index width = clog2(NWORDS); the index is never compared past NWORDS-1.

Reset
REQ-031 reset_n=0 asynchronously forces all of the following:
- state=IDLE, index=0, words_left=0.
- ep_datain=0x0000, busy=0, frame_done=0, underflow=0, capture_dropped=0.
REQ-032 Shadow buffer contents are don't-care after reset and are never visible at ep_datain until a capture is accepted.
REQ-033 Reset deassertion is synchronised internally; the first capture is accepted no earlier than the 2nd rising edge after reset_n rises.
REQ-034 Reset asserted mid-frame discards the frame; no frame_done is produced.

Verification
REQ-035 Basic frame:
- Stimulus: combinedin word k = 0x1000+k, capture, then 64 back-to-back ep_read.
- Response: ep_datain sequence 0x1000..0x103F; words_left 64->0; frame_done exactly once, on the cycle after read 64; busy low afterwards.
REQ-036 Stalls:
- Stimulus: same frame, ep_read pattern 1,0,0,1 repeated.
- Response: identical word sequence; no word skipped or repeated.
REQ-037 Snapshot isolation:
- Stimulus: capture, then change combinedin to all 0xFFFF, then read 64 words.
- Response: original values are output.
REQ-038 Dropped capture and underflow:
- Stimulus: capture during word 10; separately, ep_read in IDLE.
- Response: frame continues unchanged and capture_dropped=1; underflow=1 with ep_datain=0x0000.
- A next accepted capture clears both flags.
REQ-039 Abort:
- Stimulus: abort after 20 reads.
- Response: IDLE next cycle, words_left=0, no frame_done.
- Stimulus: abort in the same cycle as capture.
- Response: stays IDLE.
REQ-040 Reset mid-frame:
- Stimulus: assert reset_n=0 at word 33, asynchronously between edges.
- Response: all outputs at reset values immediately; a new capture after release delivers a fresh frame starting at word 0.
